// File: rtl/uart_rx_fifo_if.sv
// Receive stream between the UART receiver FIFO and its consumer (the APB register slice).
// An entry transfers on every PCLK edge where rx_valid & rx_ready; rx_valid never depends on rx_ready.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_perr;
  logic              rx_ferr;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, rx_perr, rx_ferr, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_perr, rx_ferr, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (5..DATA_W bits, optional parity, 1/2 stop bits)
// feeding a show-ahead RX FIFO with per-frame parity/framing flags.
module uart_rx_fifo #(
   parameter int DATA_W     = 9,
   parameter int FIFO_DEPTH = 16,
   parameter int OSR        = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          PCLK,
   input  logic                          PRESETn,
   input  logic                          en,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic [3:0]                    data_bits,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop_two,
   input  logic                          UART_RXD,
   uart_rx_fifo_if.master                rx_if,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overrun,
   input  logic                          overrun_clr,
   output logic                          busy
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int OSW = $clog2(OSR);
   localparam int EW  = DATA_W + 2;
   localparam logic [OSW-1:0] OS_LAST = OSW'(OSR - 1);
   localparam logic [OSW-1:0] OS_MID  = OSW'(OSR / 2 - 1);
   localparam logic [7:0]     DW8     = 8'(DATA_W);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

   logic              rxs_meta_q, rxs_q;
   logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
   state_t            state_q, state_d;
   logic              armed_q, armed_d;
   logic [OSW-1:0]    os_cnt_q, os_cnt_d;
   logic [7:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, push_q, push_d;
   logic [EW-1:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              overrun_q, overrun_d;

   logic              running, tick, sample, parity_en, pop, full, wr_en;
   logic [7:0]        nbits;
   logic [EW-1:0]     head;

   assign running   = en && (state_q != S_IDLE);
   assign tick      = running && (tick_cnt_q == '0);
   assign sample    = tick && (os_cnt_q == OS_LAST);
   assign parity_en = (parity_mode == 2'b01) || (parity_mode == 2'b10);

   always_comb begin
      if (data_bits < 4'd5)               nbits = 8'd5;
      else if ({4'd0, data_bits} > DW8)   nbits = DW8;
      else                                nbits = {4'd0, data_bits};
   end

   assign tick_cnt_d = (!running || tick_cnt_q == '0) ? baud_div : tick_cnt_q - DIV_W'(1);

   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      os_cnt_d  = os_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      push_d    = 1'b0;
      if (state_q != S_IDLE && state_q != S_START && tick)
         os_cnt_d = sample ? '0 : os_cnt_q + OSW'(1);
      if (!en) begin
         state_d = S_IDLE;
         armed_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // Arming on a high line stops a held-low line from retriggering.
               if (armed_q && !rxs_q) begin
                  state_d  = S_START;
                  os_cnt_d = '0;
                  armed_d  = 1'b0;
               end else if (rxs_q) begin
                  armed_d = 1'b1;
               end
            end
            S_START: if (tick) begin
               if (os_cnt_q == OS_MID) begin
                  os_cnt_d  = '0;
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  par_d     = 1'b0;
                  perr_d    = 1'b0;
                  ferr_d    = 1'b0;
                  state_d   = rxs_q ? S_IDLE : S_DATA;
               end else begin
                  os_cnt_d = os_cnt_q + OSW'(1);
               end
            end
            S_DATA: if (sample) begin
               shift_d   = shift_q | (DATA_W'(rxs_q) << bit_cnt_q);
               par_d     = par_q ^ rxs_q;
               bit_cnt_d = bit_cnt_q + 8'd1;
               if (bit_cnt_q == nbits - 8'd1) state_d = parity_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: if (sample) begin
               perr_d  = par_q ^ rxs_q ^ (parity_mode == 2'b10);
               state_d = S_STOP1;
            end
            S_STOP1: if (sample) begin
               ferr_d = ferr_q | ~rxs_q;
               if (stop_two) begin
                  state_d = S_STOP2;
               end else begin
                  state_d = S_IDLE;
                  push_d  = 1'b1;
               end
            end
            S_STOP2: if (sample) begin
               ferr_d  = ferr_q | ~rxs_q;
               state_d = S_IDLE;
               push_d  = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      pop       = (level_q != '0) && rx_if.rx_ready;
      full      = (level_q == LW'(FIFO_DEPTH));
      wr_en     = push_q && (!full || pop);
      wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d   = level_q;
      if (wr_en && !pop)      level_d = level_q + LW'(1);
      else if (!wr_en && pop) level_d = level_q - LW'(1);
      overrun_d = overrun_q;
      if (overrun_clr)                 overrun_d = 1'b0;
      if (push_q && full && !pop)      overrun_d = 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rxs_meta_q <= 1'b1;
         rxs_q      <= 1'b1;
         tick_cnt_q <= '0;
         state_q    <= S_IDLE;
         armed_q    <= 1'b0;
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         push_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overrun_q  <= 1'b0;
      end else begin
         rxs_meta_q <= UART_RXD;
         rxs_q      <= rxs_meta_q;
         tick_cnt_q <= tick_cnt_d;
         state_q    <= state_d;
         armed_q    <= armed_d;
         os_cnt_q   <= os_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         push_q     <= push_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overrun_q  <= overrun_d;
      end
   end

   always_ff @(posedge PCLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= {ferr_q, perr_q, shift_q};
   end

   assign head           = mem_q[rd_ptr_q];
   assign rx_if.rx_valid = (level_q != '0);
   assign rx_if.rx_data  = rx_if.rx_valid ? head[DATA_W-1:0] : '0;
   assign rx_if.rx_perr  = rx_if.rx_valid & head[DATA_W];
   assign rx_if.rx_ferr  = rx_if.rx_valid & head[DATA_W+1];
   assign fifo_level     = level_q;
   assign overrun        = overrun_q;
   assign busy           = (state_q != S_IDLE);
endmodule
